// File: rtl/riscv_pkg.sv
// Shared corev2 decode definitions: instruction width, major opcodes,
// instruction-queue entry type, issue state type and opcode pre-decode helpers.
package riscv;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } ibuf_entry_t;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } issue_state_t;

  // Load or store: two of these must not share an issue group.
  function automatic logic opc_is_mem(input logic [6:0] opc);
    return (opc == OPC_LOAD) || (opc == OPC_STORE);
  endfunction

  // Control transfer: must be the last instruction of its group.
  function automatic logic opc_is_ctrl(input logic [6:0] opc);
    return (opc == OPC_BRANCH) || (opc == OPC_JAL) || (opc == OPC_JALR);
  endfunction

  // Serialising instruction: always issues alone.
  function automatic logic opc_is_serial(input logic [6:0] opc);
    return (opc == OPC_SYSTEM) || (opc == OPC_MISC_MEM);
  endfunction

  // Anything that is not a recognised 32-bit base opcode.
  function automatic logic opc_is_illegal(input logic [6:0] opc);
    logic known;
    case (opc)
      OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR,
      OPC_SYSTEM, OPC_MISC_MEM, OPC_OP, OPC_OP_IMM,
      OPC_LUI, OPC_AUIPC: known = 1'b1;
      default:            known = 1'b0;
    endcase
    return (opc[1:0] != 2'b11) || !known;
  endfunction

endpackage

// File: rtl/dec_ibuf.sv
// Two-in / two-out circular instruction queue. Pointers carry one extra
// wrap bit; the occupancy counter is kept explicitly. Flush clears the
// pointers and count and discards any same-cycle enqueue/dequeue.
module dec_ibuf
  import riscv::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_flush,
  input  logic [1:0]                 i_enq_cnt,
  input  ibuf_entry_t                i_enq0,
  input  ibuf_entry_t                i_enq1,
  input  logic [1:0]                 i_deq_cnt,
  output ibuf_entry_t                o_head0,
  output ibuf_entry_t                o_head1,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_ready
);

  localparam int AW = $clog2(DEPTH);

  ibuf_entry_t   r_mem [DEPTH];
  logic [AW:0]   r_head;
  logic [AW:0]   r_tail;
  logic [AW:0]   r_count;

  logic [AW:0]   w_head1;
  logic [AW:0]   w_tail1;
  logic [AW:0]   w_enq_ext;
  logic [AW:0]   w_deq_ext;

  // Derived pointers and widened transfer counts.
  always_comb begin
    w_head1   = r_head + (AW+1)'(1);
    w_tail1   = r_tail + (AW+1)'(1);
    w_enq_ext = (AW+1)'(i_enq_cnt);
    w_deq_ext = (AW+1)'(i_deq_cnt);
  end

  // Queue storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_enq_cnt != 2'd0) begin
        r_mem[r_tail[AW-1:0]] <= i_enq0;
      end
      if (i_enq_cnt == 2'd2) begin
        r_mem[w_tail1[AW-1:0]] <= i_enq1;
      end
      r_tail  <= r_tail + w_enq_ext;
      r_head  <= r_head + w_deq_ext;
      r_count <= r_count + w_enq_ext - w_deq_ext;
    end
  end

  // Head entries and a full-pair space indication from registered state.
  always_comb begin
    o_head0 = r_mem[r_head[AW-1:0]];
    o_head1 = r_mem[w_head1[AW-1:0]];
    o_count = r_count;
    o_ready = (r_count <= (AW+1)'(DEPTH - 2));
  end

endmodule

// File: rtl/dec_issue_ctrl.sv
// Dual-lane decode issue controller: buffers fetch pairs in dec_ibuf,
// pre-decodes the two head entries, applies pairing rules and runs the
// RUN/HALT state machine (halt on issuing an illegal instruction).
// Optional build macro DEC_ISSUE_CTRL_PERF_EN adds pair/single/stall
// performance counters as extra outputs.
module dec_issue_ctrl
  import riscv::*;
#(
  parameter int IBUF_DEPTH = 4,
  parameter int XLEN       = riscv::XLEN
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          fet_line0_v_i,
  input  logic [XLEN-1:0]               fet_line0_instr_i,
  input  logic [XLEN-1:0]               fet_line0_pc_i,
  input  logic                          fet_line1_v_i,
  input  logic [XLEN-1:0]               fet_line1_instr_i,
  input  logic [XLEN-1:0]               fet_line1_pc_i,
  output logic                          fet_ready_o,
  output logic                          dec_line0_v_o,
  output logic [XLEN-1:0]               dec_line0_instr_o,
  output logic [XLEN-1:0]               dec_line0_pc_o,
  output logic                          dec_line1_v_o,
  output logic [XLEN-1:0]               dec_line1_instr_o,
  output logic [XLEN-1:0]               dec_line1_pc_o,
  input  logic                          ren_ready_i,
  input  logic                          flush_i,
  output logic                          halted_o,
  output logic [$clog2(IBUF_DEPTH):0]   ibuf_count_o
`ifdef DEC_ISSUE_CTRL_PERF_EN
  ,
  output logic [31:0]                   perf_pair_cnt_o,
  output logic [31:0]                   perf_single_cnt_o,
  output logic [31:0]                   perf_stall_cnt_o
`endif
);

  localparam int CNT_W = $clog2(IBUF_DEPTH) + 1;

  issue_state_t      r_state;
  ibuf_entry_t       w_head0;
  ibuf_entry_t       w_head1;
  ibuf_entry_t       w_enq0;
  ibuf_entry_t       w_enq1;
  logic [CNT_W-1:0]  w_count;
  logic              w_fet_ready;
  logic [1:0]        w_enq_cnt;
  logic [1:0]        w_deq_cnt;
  logic              w_lane0_v;
  logic              w_lane1_v;
  logic              w_mem0, w_mem1, w_ctrl0, w_ser0, w_ser1, w_ill0, w_ill1;
  logic              w_run;

  dec_ibuf #(
    .DEPTH (IBUF_DEPTH)
  ) u_ibuf (
    .clk       (clk),
    .reset     (reset),
    .i_flush   (flush_i),
    .i_enq_cnt (w_enq_cnt),
    .i_enq0    (w_enq0),
    .i_enq1    (w_enq1),
    .i_deq_cnt (w_deq_cnt),
    .o_head0   (w_head0),
    .o_head1   (w_head1),
    .o_count   (w_count),
    .o_ready   (w_fet_ready)
  );

  // Fetch-side enqueue: only whole pairs are accepted, slot 1 rides on slot 0.
  always_comb begin
    w_enq0.instr = fet_line0_instr_i;
    w_enq0.pc    = fet_line0_pc_i;
    w_enq1.instr = fet_line1_instr_i;
    w_enq1.pc    = fet_line1_pc_i;
    if (w_fet_ready && fet_line0_v_i) begin
      w_enq_cnt = fet_line1_v_i ? 2'd2 : 2'd1;
    end else begin
      w_enq_cnt = 2'd0;
    end
  end

  // Pre-decode of the two head entries and lane pairing decision.
  always_comb begin
    w_mem0  = opc_is_mem(w_head0.instr[6:0]);
    w_mem1  = opc_is_mem(w_head1.instr[6:0]);
    w_ctrl0 = opc_is_ctrl(w_head0.instr[6:0]);
    w_ser0  = opc_is_serial(w_head0.instr[6:0]);
    w_ser1  = opc_is_serial(w_head1.instr[6:0]);
    w_ill0  = opc_is_illegal(w_head0.instr[6:0]);
    w_ill1  = opc_is_illegal(w_head1.instr[6:0]);
    w_run   = (r_state == RUN);

    w_lane0_v = w_run && (w_count != CNT_W'(0));
    w_lane1_v = w_run && (w_count >= CNT_W'(2))
                && !(w_mem0 && w_mem1) && !w_ctrl0
                && !w_ser0 && !w_ser1 && !w_ill0 && !w_ill1;

    if (ren_ready_i) begin
      w_deq_cnt = {1'b0, w_lane0_v} + {1'b0, w_lane1_v};
    end else begin
      w_deq_cnt = 2'd0;
    end
  end

  // RUN/HALT state: halt once an illegal head leaves on lane 0; flush resumes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RUN;
    end else if (flush_i) begin
      r_state <= RUN;
    end else begin
      case (r_state)
        RUN:     r_state <= (w_lane0_v && ren_ready_i && w_ill0) ? HALT : RUN;
        HALT:    r_state <= HALT;
        default: r_state <= RUN;
      endcase
    end
  end

  // Issue outputs driven straight from the queue head so the decoder can flop them.
  always_comb begin
    fet_ready_o       = w_fet_ready;
    dec_line0_v_o     = w_lane0_v;
    dec_line0_instr_o = w_head0.instr;
    dec_line0_pc_o    = w_head0.pc;
    dec_line1_v_o     = w_lane1_v;
    dec_line1_instr_o = w_head1.instr;
    dec_line1_pc_o    = w_head1.pc;
    halted_o          = (r_state == HALT);
    ibuf_count_o      = w_count;
  end

`ifdef DEC_ISSUE_CTRL_PERF_EN
  logic [31:0] r_perf_pair;
  logic [31:0] r_perf_single;
  logic [31:0] r_perf_stall;

  // Performance counters: cleared only by reset, free-running with wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_pair   <= 32'd0;
      r_perf_single <= 32'd0;
      r_perf_stall  <= 32'd0;
    end else begin
      if (ren_ready_i && w_lane0_v && w_lane1_v) begin
        r_perf_pair <= r_perf_pair + 32'd1;
      end
      if (ren_ready_i && w_lane0_v && !w_lane1_v) begin
        r_perf_single <= r_perf_single + 32'd1;
      end
      if (w_run && (w_count != CNT_W'(0)) && !ren_ready_i) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
    end
  end

  // Counter outputs.
  always_comb begin
    perf_pair_cnt_o   = r_perf_pair;
    perf_single_cnt_o = r_perf_single;
    perf_stall_cnt_o  = r_perf_stall;
  end
`endif

endmodule
